// File: rtl/scp_pkg.sv
// Shared definitions for the add/noop multi-cycle control sequencer:
// instruction encodings, MIPS field positions, FSM states and instruction classes.
package scp_pkg;

    // Instruction encodings
    localparam logic [5:0]  OPC_RTYPE  = 6'h00;
    localparam logic [5:0]  FUNCT_ADD  = 6'h20;
    localparam logic [31:0] INSTR_NOOP = 32'h0000_0000;

    // MIPS R-type field bit positions
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } ctrl_state_t;

    // Decoded instruction class
    typedef enum logic [1:0] {
        CLS_NOOP    = 2'd0,
        CLS_ADD     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } instr_cls_t;

endpackage

// File: rtl/scp_decode.sv
// Combinational instruction decoder: classifies the instruction register and
// extracts the register-file address fields.
module scp_decode
    import scp_pkg::*;
(
    input  logic [31:0] ir_i,
    output instr_cls_t  cls_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o
);

    assign rs_o = ir_i[RS_MSB:RS_LSB];
    assign rt_o = ir_i[RT_MSB:RT_LSB];
    assign rd_o = ir_i[RD_MSB:RD_LSB];

    // Classify: the all-zero word is a noop (checked first, it is also R-type),
    // an R-type with zero shamt and the add funct is an add, everything else is illegal.
    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (ir_i == INSTR_NOOP) begin
            cls_o = CLS_NOOP;
        end else if ((ir_i[OPC_MSB:OPC_LSB] == OPC_RTYPE) &&
                     (ir_i[SHAMT_MSB:SHAMT_LSB] == 5'd0) &&
                     (ir_i[FUNCT_MSB:FUNCT_LSB] == FUNCT_ADD)) begin
            cls_o = CLS_ADD;
        end
    end

endmodule

// File: rtl/scp_mc_ctrl.sv
// Multi-cycle control sequencer for the add/noop datapath. Owns PC and IR,
// fetches over a req/ack port and steps decode/execute/writeback.
// Optional retired-instruction counter enabled by defining SCP_RETIRE_CNT_EN;
// otherwise retire_cnt is tied to zero.
module scp_mc_ctrl
    import scp_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        rf_ra1,
    output logic [4:0]        rf_ra2,
    output logic [4:0]        rf_wa,
    output logic              rf_we,
    output logic              alu_en,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       retire_cnt
);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              halted_q, halted_d;

    instr_cls_t        cls;
    logic [4:0]        rs, rt, rd;

    scp_decode u_decode (
        .ir_i  (ir_q),
        .cls_o (cls),
        .rs_o  (rs),
        .rt_o  (rt),
        .rd_o  (rd)
    );

    // Next-state logic: run is only consulted at instruction boundaries,
    // so dropping it mid-instruction lets the instruction finish.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_NOOP: state_d = run ? ST_FETCH : ST_IDLE;
                    CLS_ADD:  state_d = ST_EXECUTE;
                    default: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                endcase
            end
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = run ? ST_FETCH : ST_IDLE;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State, PC, IR and sticky halt registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Strobes decoded from the current state; being combinational, an async
    // reset drops imem_req in the same instant it forces IDLE.
    always_comb begin
        imem_req = (state_q == ST_FETCH);
        alu_en   = (state_q == ST_EXECUTE);
        rf_we    = (state_q == ST_WRITEBACK) && (rd != 5'd0);
        retire   = ((state_q == ST_DECODE) && (cls == CLS_NOOP)) ||
                   (state_q == ST_WRITEBACK);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign rf_ra1    = rs;
    assign rf_ra2    = rt;
    assign rf_wa     = rd;

`ifdef SCP_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = retire ? (cnt_q + 32'd1) : cnt_q;

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_scp_mc_ctrl.sv
// Directed testbench for scp_mc_ctrl: main instance at RESET_PC=0 and a
// second instance at RESET_PC=FFFF_FFFC for the PC wrap case.
module tb_scp_mc_ctrl;

    logic        clk;
    logic        rst;
    logic        run, imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, rf_we, alu_en, retire, halted;
    logic [31:0] imem_addr, pc, retire_cnt;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;

    logic        run_w, ack_w;
    logic [31:0] rdata_w;
    logic        req_w, we_w, alu_w, retire_w, halted_w;
    logic [31:0] addr_w, pc_w, cnt_w;
    logic [4:0]  ra1_w, ra2_w, wa_w;

    int n_checks = 0;
    int n_errors = 0;

    scp_mc_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .alu_en     (alu_en),
        .retire     (retire),
        .halted     (halted),
        .pc         (pc),
        .retire_cnt (retire_cnt)
    );

    scp_mc_ctrl #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .run        (run_w),
        .imem_req   (req_w),
        .imem_addr  (addr_w),
        .imem_ack   (ack_w),
        .imem_rdata (rdata_w),
        .rf_ra1     (ra1_w),
        .rf_ra2     (ra2_w),
        .rf_wa      (wa_w),
        .rf_we      (we_w),
        .alu_en     (alu_w),
        .retire     (retire_w),
        .halted     (halted_w),
        .pc         (pc_w),
        .retire_cnt (cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    initial begin
        int req_cnt;
        int bad;
        int nf;
        int nr;
        logic [31:0] exp_addr;
        logic [31:0] exp_cnt;

        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        run_w = 1'b0; ack_w = 1'b0; rdata_w = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_req",    imem_req,   0);
        check_val("rst_pc",     pc,         0);
        check_val("rst_halted", halted,     0);
        check_val("rst_retire", retire,     0);
        check_val("rst_cnt",    retire_cnt, 0);
        check_val("rst_pc_w",   pc_w,       32'hFFFF_FFFC);
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_norun_req", imem_req, 0);

        // Noop, zero-wait ack: retire in cycle 2
        run = 1'b1;
        @(negedge clk);
        check_val("noop_req",  imem_req,  1);
        check_val("noop_addr", imem_addr, 0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("noop_retire", retire, 1);
        check_val("noop_pc",     pc,     4);
        check_val("noop_alu",    alu_en, 0);
        check_val("noop_we",     rf_we,  0);
        check_val("noop_req_dec", imem_req, 0);
        @(negedge clk);
        check_val("next_req",    imem_req,  1);
        check_val("next_addr",   imem_addr, 4);
        check_val("next_retire", retire,    0);

        // add $3,$1,$2
        imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("add_ra1",    rf_ra1, 1);
        check_val("add_ra2",    rf_ra2, 2);
        check_val("add_wa",     rf_wa,  3);
        check_val("add_c2_ret", retire, 0);
        check_val("add_c2_alu", alu_en, 0);
        @(negedge clk);
        check_val("add_c3_alu", alu_en,   1);
        check_val("add_c3_we",  rf_we,    0);
        check_val("add_c3_req", imem_req, 0);
        @(negedge clk);
        check_val("add_c4_we",  rf_we,  1);
        check_val("add_c4_ret", retire, 1);
        check_val("add_c4_alu", alu_en, 0);
        check_val("add_c4_wa",  rf_wa,  3);
        @(negedge clk);
        check_val("add0_addr", imem_addr, 8);

        // add with rd=0: retires, no write
        imem_ack = 1'b1; imem_rdata = 32'h0022_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("add0_retire", retire, 1);
        check_val("add0_we",     rf_we,  0);
        run = 1'b0;
        @(negedge clk);
        check_val("idle_req", imem_req, 0);
        check_val("idle_pc",  pc,       12);

        // Stray ack in IDLE is ignored
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("stray_halted", halted,   0);
        check_val("stray_pc",     pc,       12);
        check_val("stray_req",    imem_req, 0);

        // Ack delayed 3 cycles, run dropped mid-fetch
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) req_cnt++;
            if (i == 3) begin
                imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check_val("dly_req_cycles", req_cnt, 4);
        check_val("dly_retire",     retire,  1);
        check_val("dly_pc",         pc,      16);
        req_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
        end
        check_val("dly_no_new_req", req_cnt, 0);

        // Illegal instruction (lw) after a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; run = 1'b1;
        @(negedge clk);
        check_val("lw_req",  imem_req,  1);
        check_val("lw_addr", imem_addr, 0);
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("lw_dec_retire", retire, 0);
        check_val("lw_dec_halted", halted, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            imem_ack = (i % 2) == 1; imem_rdata = 32'h0000_0000;
            @(negedge clk);
            if (imem_req || alu_en || rf_we || retire) bad++;
            if (pc != 32'd4) bad++;
            if (!halted) bad++;
        end
        imem_ack = 1'b0;
        check_val("halt_bad_cycles", bad,    0);
        check_val("halt_halted",     halted, 1);
        check_val("halt_pc",         pc,     4);

        // Async reset leaves HALT
        rst = 1'b0;
        #1;
        check_val("halt_rst_halted", halted, 0);
        check_val("halt_rst_pc",     pc,     0);
        @(negedge clk);
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        check_val("halt_rst_idle_req", imem_req, 0);

        // Reset mid-fetch drops req at once; late ack ignored
        run = 1'b1;
        @(negedge clk);
        check_val("mf_req", imem_req, 1);
        rst = 1'b0;
        #1;
        check_val("mf_req_rst", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        @(negedge clk);
        run = 1'b0; rst = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check_val("mf_pc",     pc,       0);
        check_val("mf_req2",   imem_req, 0);
        check_val("mf_retire", retire,   0);

        // PC wrap on second instance with a noop stream
        run_w = 1'b1; ack_w = 1'b1; rdata_w = 32'h0000_0000;
        nf = 0; nr = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_w) begin
                exp_addr = 32'hFFFF_FFFC + (nf * 4);
                if (nf < 5) check_val($sformatf("wrap_addr%0d", nf), addr_w, exp_addr);
                nf++;
            end
            if (retire_w) begin
                nr++;
                if (nr == 5) run_w = 1'b0;
            end
        end
        ack_w = 1'b0;
        check_val("wrap_fetches", nf,   5);
        check_val("wrap_retires", nr,   5);
        check_val("wrap_pc",      pc_w, 32'h0000_0010);
`ifdef SCP_RETIRE_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        check_val("wrap_retire_cnt", cnt_w, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scp_mc_ctrl.md
Name: scp_mc_ctrl

Overview:
- Multi-cycle control sequencer for the add/noop processor datapath.
- Fetches 32-bit MIPS-encoded instructions over a req/ack instruction-memory port, decodes them, and steps the datapath through decode, execute and writeback.
- Owns the PC and instruction register; drives register-file addresses, ALU enable and write enable.
- Sits between instruction memory and the existing register file/ALU datapath.

Parameters:
- ADDR_W, 32, PC / instruction address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = keep executing, 0 = stop at the next instruction boundary.
- imem_req  out  1  fetch request, held until acked.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- rf_ra1  out  5  rs field of IR.
- rf_ra2  out  5  rt field of IR.
- rf_wa  out  5  rd field of IR.
- rf_we  out  1  register-file write strobe.
- alu_en  out  1  ALU result-latch enable.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky; illegal instruction seen.
- pc  out  ADDR_W  current PC.
- retire_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, IR=0.
  - imem_req, rf_we, alu_en, retire, halted all 0; retire_cnt=0.
  - Reset asserted mid-fetch drops imem_req immediately; any late imem_ack is ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: all strobes 0. run=1 -> FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc; req stays high until ack.
  - On imem_ack: IR <= imem_rdata, pc <= pc+4 (modulo 2^ADDR_W, wraps silently), -> DECODE.
  - run is not sampled during FETCH.
- DECODE: classify IR.
  - NOOP (IR == 32'h0000_0000): retire=1; -> FETCH if run else IDLE.
  - ADD (opcode[31:26]=6'h00, shamt[10:6]=0, funct[5:0]=6'h20): -> EXECUTE.
  - Anything else: -> HALT, halted=1, no retire.
- EXECUTE: alu_en=1 for exactly one cycle; -> WRITEBACK.
- WRITEBACK:
  - rf_we=1 unless rd==0 (a write to $0 is suppressed but still retires).
  - retire=1; -> FETCH if run else IDLE.
- HALT: terminal; all strobes 0, imem_req=0, pc frozen. Exit only via reset.
- Latency with zero-wait ack: noop 2 cycles, add 4 cycles, FETCH entry to retire. Each ack wait cycle adds 1.
- rf_ra1/rf_ra2/rf_wa are combinational from IR and stable from DECODE through WRITEBACK.
- Only one of rf_we, alu_en and imem_req is high in any cycle.
- run deasserting during an instruction never aborts it. The instruction completes, then the block enters IDLE.
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro SCP_RETIRE_CNT_EN.
  - Defined: retire_cnt increments by 1 on every retire pulse, wraps at 2^32, and clears on reset.
  - Undefined: no counter is built and retire_cnt is tied to 0. The port is always present.

Decomposition:
- Package scp_pkg holds:
  - OPC_RTYPE=6'h00, FUNCT_ADD=6'h20, INSTR_NOOP=32'h0.
  - Field bit positions.
  - State enum ctrl_state_t.
  - Instruction class enum {CLS_NOOP, CLS_ADD, CLS_ILLEGAL}.
- Sub-module scp_decode: combinational IR -> class and rs/rt/rd fields. The FSM, PC and IR stay in scp_mc_ctrl.

Test Plan:
- Reset, run=1, ack same cycle, rdata=32'h0 -> imem_addr=0; retire 2 cycles after FETCH entry; next imem_addr=4; rf_we and alu_en never high.
- rdata=32'h0022_1820 (add $3,$1,$2) -> rf_ra1=1, rf_ra2=2, rf_wa=3; alu_en pulses in cycle 3; rf_we and retire in cycle 4.
- add with rd=0 (32'h0022_0020) -> retire=1, rf_we stays 0.
- rdata=32'h8C01_0000 (lw) -> halted=1 after DECODE; imem_req stays 0; pc frozen at 4 for 20 cycles; rst low->high returns to IDLE with halted=0.
- ack delayed 3 cycles, run dropped mid-fetch -> imem_req high 4 cycles, instruction retires, then IDLE with no new req.
- RESET_PC=32'hFFFF_FFFC, noop stream -> pc wraps to 0 and fetch continues. With SCP_RETIRE_CNT_EN, 5 retires give retire_cnt=5; without it, retire_cnt=0.
